instr_encoder: RTL and testbench

Sequential br32 instruction encoder: accepts abstract operation requests over a valid/ready port and emits encoded 32-bit br32 instruction words over a second valid/ready port. Requests whose 32-bit constant needs both halves (MOVI) expand to two words; unencodable requests raise a one-cycle error and emit nothing. Sits in the debug/injection path, feeding words toward fetch; its output must round-trip through the core decoder.

---
 rtl/instr_encoder.sv | 180 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// br32 instruction encoder: turns abstract operation requests into encoded 32-bit words.
// A MOVI with both constant halves non-zero expands into two words. Unencodable requests raise a one-cycle err.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_kind,
  input  logic [5:0]  req_sub,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err
);

  localparam logic [2:0] MOV_OPC     = 3'd3;
  localparam logic [2:0] KIND_ALU_RI = 3'd0;
  localparam logic [2:0] KIND_ALU_RR = 3'd1;
  localparam logic [2:0] KIND_LOAD   = 3'd2;
  localparam logic [2:0] KIND_STORE  = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;
  localparam logic [2:0] KIND_MOVI   = 3'd5;
  localparam logic [2:0] KIND_ADR    = 3'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    LAST  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] hold_word;

  logic        imm_hi_zero;
  logic        imm_lo_zero;
  logic        imm_fits16;
  logic        br_fits;

  logic        enc_bad;
  logic        enc_two;
  logic [31:0] enc_w0;
  logic [31:0] enc_w1;

  logic        accept;
  logic        load_new;

  // Immediate format: the 16-bit immediate overlays the rs2 field.
  function automatic logic [31:0] pack_i(input logic [15:0] imm16,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rd,
                                         input logic [5:0]  opc);
    return {imm16, rs1, rd, opc};
  endfunction

  function automatic logic [5:0] alu_ri_opc(input logic high, input logic [2:0] op);
    return {2'b01, high, op};
  endfunction

  assign imm_hi_zero = (req_imm[31:16] == 16'd0);
  assign imm_lo_zero = (req_imm[15:0] == 16'd0);
  assign imm_fits16  = (&req_imm[31:15]) || (~|req_imm[31:15]);
  assign br_fits     = ((&req_imm[31:27]) || (~|req_imm[31:27])) && (req_imm[1:0] == 2'b00);

  always_comb begin
    enc_bad = 1'b0;
    enc_two = 1'b0;
    enc_w0  = 32'd0;
    enc_w1  = 32'd0;
    case (req_kind)
      KIND_ALU_RI: begin
        if (imm_hi_zero) begin
          enc_w0 = pack_i(req_imm[15:0], req_rs1, req_rd, alu_ri_opc(1'b0, req_sub[2:0]));
        end else if (imm_lo_zero) begin
          enc_w0 = pack_i(req_imm[31:16], req_rs1, req_rd, alu_ri_opc(1'b1, req_sub[2:0]));
        end else begin
          enc_bad = 1'b1;
        end
      end
      KIND_ALU_RR: begin
        enc_w0 = {5'b00000, req_sub, req_rs2, req_rs1, req_rd, 6'b111110};
      end
      KIND_LOAD: begin
        if (imm_fits16) begin
          enc_w0 = pack_i(req_imm[15:0], req_rs1, req_rd,
                          {2'b10, req_sub[1:0], 1'b0, req_sub[2]});
        end else begin
          enc_bad = 1'b1;
        end
      end
      KIND_STORE: begin
        if (imm_fits16) begin
          enc_w0 = pack_i(req_imm[15:0], req_rs1, req_rd, {2'b10, req_sub[1:0], 2'b10});
        end else begin
          enc_bad = 1'b1;
        end
      end
      KIND_BRANCH: begin
        // Word offset occupies everything above the opcode; no register fields.
        if (!br_fits) begin
          enc_bad = 1'b1;
        end else if (req_sub[3]) begin
          enc_w0 = {req_imm[27:2], 3'b001, 2'b11, req_sub[4]};
        end else if (req_sub[2:1] == 2'b11) begin
          enc_bad = 1'b1;
        end else begin
          enc_w0 = {req_imm[27:2], 3'b001, req_sub[2:0]};
        end
      end
      KIND_MOVI: begin
        if (imm_hi_zero) begin
          enc_w0 = pack_i(req_imm[15:0], 5'd0, req_rd, alu_ri_opc(1'b0, MOV_OPC));
        end else if (imm_lo_zero) begin
          enc_w0 = pack_i(req_imm[31:16], 5'd0, req_rd, alu_ri_opc(1'b1, MOV_OPC));
        end else begin
          enc_two = 1'b1;
          enc_w0  = pack_i(req_imm[31:16], 5'd0, req_rd, alu_ri_opc(1'b1, MOV_OPC));
          enc_w1  = pack_i(req_imm[15:0], req_rd, req_rd, alu_ri_opc(1'b0, MOV_OPC));
        end
      end
      KIND_ADR: begin
        if (imm_fits16) begin
          enc_w0 = pack_i(req_imm[15:0], 5'd0, req_rd, 6'b110100);
        end else begin
          enc_bad = 1'b1;
        end
      end
      default: begin
        enc_bad = 1'b1;
      end
    endcase
  end

  // Ready only when the output stage is empty or its final word leaves this cycle.
  assign req_ready = rst_n && ((state == IDLE) || ((state == LAST) && out_ready));
  assign accept    = req_valid && req_ready;
  assign load_new  = accept && !enc_bad;
  assign out_valid = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_instr <= 32'd0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      hold_word <= 32'd0;
    end else begin
      err <= accept && enc_bad;
      if (load_new) begin
        out_instr <= enc_w0;
        out_last  <= !enc_two;
        hold_word <= enc_w1;
        state     <= enc_two ? FIRST : LAST;
      end else begin
        case (state)
          FIRST: begin
            if (out_ready) begin
              out_instr <= hold_word;
              out_last  <= 1'b1;
              state     <= LAST;
            end
          end
          LAST: begin
            if (out_ready) begin
              state <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus randomized traffic
// compared every cycle against a queue-based model of the emitted word stream.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_kind = 3'd0;
  logic [5:0]  req_sub = 6'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [4:0]  req_rs1 = 5'd0;
  logic [4:0]  req_rs2 = 5'd0;
  logic [31:0] req_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  int total = 0;
  int bad = 0;

  logic [32:0] exp_q[$];
  bit          err_pending = 1'b0;

  instr_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_sub   (req_sub),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .req_imm   (req_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] iform(input logic [31:0] imm16, input int rs1, input int rd,
                                        input int opc);
    return imm16 * 32'd65536 + rs1 * 2048 + rd * 64 + opc;
  endfunction

  // Reference encoding from the instruction-set rules; n==0 means unencodable.
  function automatic void modelEncode(input int kind, input int sub, input int rd, input int rs1,
                                      input int rs2, input logic [31:0] imm,
                                      output int n, output logic [31:0] w0, output logic [31:0] w1);
    longint      simm;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          fits16;
    simm   = longint'($signed(imm));
    lo     = imm % 32'd65536;
    hi     = imm / 32'd65536;
    fits16 = (simm >= -32768) && (simm <= 32767);
    n  = 1;
    w0 = 32'd0;
    w1 = 32'd0;
    case (kind)
      0: begin
        if (hi == 0)      w0 = iform(lo, rs1, rd, 16 + sub % 8);
        else if (lo == 0) w0 = iform(hi, rs1, rd, 24 + sub % 8);
        else              n = 0;
      end
      1: w0 = sub * 32'd2097152 + rs2 * 65536 + rs1 * 2048 + rd * 64 + 62;
      2: begin
        if (fits16) w0 = iform(lo, rs1, rd, 32 + (sub % 4) * 4 + (sub / 4) % 2);
        else        n = 0;
      end
      3: begin
        if (fits16) w0 = iform(lo, rs1, rd, 32 + (sub % 4) * 4 + 2);
        else        n = 0;
      end
      4: begin
        if (simm % 4 != 0 || simm < -(64'sd1 <<< 27) || simm >= (64'sd1 <<< 27)) n = 0;
        else if ((sub / 8) % 2 == 1) w0 = ((imm / 4) % 32'h0400_0000) * 64 + 14 + (sub / 16) % 2;
        else if (sub % 8 >= 6)       n = 0;
        else                         w0 = ((imm / 4) % 32'h0400_0000) * 64 + 8 + sub % 8;
      end
      5: begin
        if (hi == 0)      w0 = iform(lo, 0, rd, 19);
        else if (lo == 0) w0 = iform(hi, 0, rd, 27);
        else begin
          n  = 2;
          w0 = iform(hi, 0, rd, 27);
          w1 = iform(lo, rd, rd, 19);
        end
      end
      6: begin
        if (fits16) w0 = iform(lo, 0, rd, 52);
        else        n = 0;
      end
      default: n = 0;
    endcase
  endfunction

  function automatic bit modelReady();
    return rst_n && ((exp_q.size() == 0) || (exp_q.size() == 1 && out_ready));
  endfunction

  // Model update: retire the head word on a handshake, then append the accepted request.
  always @(posedge clk or negedge rst_n) begin
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          acc;
    if (!rst_n) begin
      exp_q.delete();
      err_pending = 1'b0;
    end else begin
      acc = req_valid && modelReady();
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      err_pending = 1'b0;
      if (acc) begin
        modelEncode(int'(req_kind), int'(req_sub), int'(req_rd), int'(req_rs1), int'(req_rs2),
                    req_imm, n, w0, w1);
        if (n == 0) err_pending = 1'b1;
        else if (n == 1) exp_q.push_back({1'b1, w0});
        else begin
          exp_q.push_back({1'b0, w0});
          exp_q.push_back({1'b1, w1});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("req_ready", 32'(req_ready), 32'(modelReady()));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      checkOutput("err", 32'(err), 32'(err_pending));
      if (exp_q.size() != 0) begin
        checkOutput("out_instr", out_instr, exp_q[0][31:0]);
        checkOutput("out_last", 32'(out_last), 32'(exp_q[0][32]));
      end
    end
  end

  // Call only just after a rising edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [2:0] kind, input logic [5:0] sub, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit got;
    bit rdy;
    req_kind  = kind;
    req_sub   = sub;
    req_rd    = rd;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
    req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) got = 1'b1;
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    #1 req_valid = 1'b0;
  endtask

  task automatic sendAndExpect(input string name, input logic [2:0] kind, input logic [5:0] sub,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic [31:0] exp_word);
    out_ready = 1'b1;
    applyStimulus(kind, sub, rd, rs1, rs2, imm);
    @(negedge clk);
    checkOutput(name, out_instr, exp_word);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic sendAndExpectErr(input string name, input logic [2:0] kind, input logic [5:0] sub,
                                  input logic [31:0] imm);
    out_ready = 1'b1;
    applyStimulus(kind, sub, 5'd1, 5'd2, 5'd3, imm);
    @(negedge clk);
    checkOutput({name, "_err"}, 32'(err), 32'd1);
    checkOutput({name, "_novalid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput({name, "_errdrop"}, 32'(err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    int          accepts;
    int          words;
    int          mode;

    // Pin the reference model with hand-computed encodings.
    modelEncode(5, 0, 5, 0, 0, 32'h1234_5678, n, w0, w1);
    checkOutput("model_movi_n", 32'(n), 32'd2);
    checkOutput("model_movi_w0", w0, 32'h1234_015B);
    checkOutput("model_movi_w1", w1, 32'h5678_2953);
    modelEncode(4, 6'h02, 0, 0, 0, 32'hFFFF_FFF8, n, w0, w1);
    checkOutput("model_br_cond", w0, 32'hFFFF_FF8A);
    modelEncode(2, 6'h02, 3, 4, 0, 32'hFFFF_FFFC, n, w0, w1);
    checkOutput("model_load", w0, 32'hFFFC_20E8);
    modelEncode(0, 3, 0, 0, 0, 32'h0001_0001, n, w0, w1);
    checkOutput("model_alu_ri_bad", 32'(n), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_instr", out_instr, 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // MOVI split held under backpressure.
    out_ready = 1'b0;
    applyStimulus(3'd5, 6'd0, 5'd5, 5'd9, 5'd9, 32'h1234_5678);
    @(negedge clk);
    checkOutput("movi_w0", out_instr, 32'h1234_015B);
    checkOutput("movi_w0_last", 32'(out_last), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("movi_w0_hold", out_instr, 32'h1234_015B);
      checkOutput("movi_stall_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("movi_w1", out_instr, 32'h5678_2953);
    checkOutput("movi_w1_last", 32'(out_last), 32'd1);
    @(posedge clk);
    #1;

    sendAndExpect("br_cond", 3'd4, 6'h02, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF8, 32'hFFFF_FF8A);
    sendAndExpect("br_link", 3'd4, 6'h18, 5'd0, 5'd0, 5'd0, 32'h0000_0100, 32'h0000_100F);
    sendAndExpectErr("br_cond6", 3'd4, 6'h06, 32'h0000_0010);
    sendAndExpect("load", 3'd2, 6'h02, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFC, 32'hFFFC_20E8);
    sendAndExpectErr("load_range", 3'd2, 6'h02, 32'h0000_8000);
    sendAndExpect("alu_rr", 3'd1, 6'h21, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0423_107E);
    sendAndExpectErr("alu_ri_both", 3'd0, 6'h03, 32'h0001_0001);
    sendAndExpect("alu_ri_high", 3'd0, 6'h03, 5'd0, 5'd0, 5'd0, 32'h0001_0000, 32'h0001_001B);
    sendAndExpectErr("kind7", 3'd7, 6'h00, 32'd0);

    // Ten back-to-back ALU_RR requests must stream one word per cycle.
    out_ready = 1'b1;
    req_kind  = 3'd1;
    req_valid = 1'b1;
    accepts = 0;
    words = 0;
    for (int i = 0; i < 10; i++) begin
      req_sub = 6'(i);
      req_rd  = 5'(i + 1);
      @(negedge clk);
      if (req_ready) accepts++;
      if (i > 0 && out_valid) words++;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (out_valid) words++;
    checkOutput("b2b_accepts", 32'(accepts), 32'd10);
    checkOutput("b2b_words", 32'(words), 32'd10);
    @(posedge clk);
    #1;

    // Reset while the second MOVI word is pending.
    out_ready = 1'b0;
    applyStimulus(3'd5, 6'd0, 5'd7, 5'd0, 5'd0, 32'hABCD_0001);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_instr", out_instr, 32'd0);
    checkOutput("mid_rst_last", 32'(out_last), 32'd0);
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    words = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) words++;
    end
    checkOutput("post_rst_words", 32'(words), 32'd0);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_kind  = 3'($urandom_range(0, 7));
      req_sub   = 6'($urandom);
      req_rd    = 5'($urandom);
      req_rs1   = 5'($urandom);
      req_rs2   = 5'($urandom);
      mode = $urandom_range(0, 5);
      case (mode)
        0: req_imm = 32'($urandom_range(0, 65535));
        1: req_imm = $urandom << 16;
        2: req_imm = $urandom;
        3: req_imm = 32'(signed'(16'($urandom)));
        4: req_imm = {{5{1'($urandom)}}, 27'($urandom)} & 32'hFFFF_FFFC;
        default: req_imm = 32'd0;
      endcase
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
